// File: rtl/dial_pkg.sv
// Shared constants and state encoding for the dial tracker.
package dial_pkg;

  localparam int DIAL_SIZE         = 100;
  localparam int START_POS_DEFAULT = 50;

  localparam logic DIR_L = 1'b0;
  localparam logic DIR_R = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/bcd2bin_2d.sv
// Two-digit BCD to binary conversion; out-of-range digits are clamped to 9 and flagged.
module bcd2bin_2d (
  input  logic [7:0] bcd,
  output logic [6:0] bin,
  output logic       err
);

  logic [3:0] tens;
  logic [3:0] ones;

  always_comb begin
    tens = (bcd[7:4] > 4'd9) ? 4'd9 : bcd[7:4];
    ones = (bcd[3:0] > 4'd9) ? 4'd9 : bcd[3:0];
    err  = (bcd[7:4] > 4'd9) || (bcd[3:0] > 4'd9);
    bin  = 7'(tens) * 7'd10 + 7'(ones);
  end

endmodule

// File: rtl/dial_tracker.sv
// Tracks the 0..99 dial position and counts clicks landing on zero, one rotation per handshake.
// Define DIAL_LAND_COUNT_EN to add land_count (rotations that finish exactly on zero).
module dial_tracker
  import dial_pkg::*;
#(
  parameter int COUNT_W   = 16,
  parameter int START_POS = START_POS_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_dir,
  input  logic [3:0]         in_mod,
  input  logic [7:0]         in_val,
  input  logic               in_last,
  input  logic               restart,
  output logic [6:0]         pos_bin,
  output logic [COUNT_W-1:0] zero_count,
`ifdef DIAL_LAND_COUNT_EN
  output logic [COUNT_W-1:0] land_count,
`endif
  output logic               bcd_err,
  output logic               done
);

  state_t state, state_nxt;

  logic       accept;
  logic [6:0] m_bin;
  logic       digit_err;

  logic       s1_valid;
  logic       s1_dir;
  logic       s1_last;
  logic [3:0] s1_h;
  logic [6:0] s1_m;

  logic [7:0]         sum_r;
  logic               wrap_r;
  logic               cross_l;
  logic [6:0]         pos_new;
  logic [4:0]         inc;
  logic [COUNT_W:0]   zc_sum;
  logic [COUNT_W-1:0] zc_next;

  assign in_ready = (state == RUN);
  assign accept   = in_valid && in_ready;

  bcd2bin_2d u_bcd (
    .bcd (in_val),
    .bin (m_bin),
    .err (digit_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = RUN;
      RUN:     if (accept && in_last) state_nxt = DONE;
      DONE:    state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
    if (restart) state_nxt = IDLE;
  end

  // Stage 2 arithmetic: a left turn crosses zero only if it starts off zero and reaches it.
  assign sum_r   = {1'b0, pos_bin} + {1'b0, s1_m};
  assign wrap_r  = (sum_r >= 8'(DIAL_SIZE));
  assign cross_l = (pos_bin != 7'd0) && (s1_m >= pos_bin) && (s1_m != 7'd0);

  always_comb begin
    pos_new = pos_bin;
    inc     = {1'b0, s1_h};
    if (s1_dir == DIR_R) begin
      pos_new = wrap_r ? 7'(sum_r - 8'(DIAL_SIZE)) : sum_r[6:0];
      inc     = {1'b0, s1_h} + {4'd0, wrap_r};
    end else begin
      pos_new = (s1_m > pos_bin) ? (pos_bin - s1_m + 7'(DIAL_SIZE)) : (pos_bin - s1_m);
      inc     = {1'b0, s1_h} + {4'd0, cross_l};
    end
  end

  assign zc_sum  = {1'b0, zero_count} + (COUNT_W+1)'(inc);
  assign zc_next = zc_sum[COUNT_W] ? '1 : zc_sum[COUNT_W-1:0];

  // Restart outranks accept and flushes stage 1 along with all results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_dir     <= 1'b0;
      s1_last    <= 1'b0;
      s1_h       <= 4'd0;
      s1_m       <= 7'd0;
      pos_bin    <= 7'(START_POS);
      zero_count <= '0;
      bcd_err    <= 1'b0;
      done       <= 1'b0;
    end else if (restart) begin
      s1_valid   <= 1'b0;
      s1_dir     <= 1'b0;
      s1_last    <= 1'b0;
      s1_h       <= 4'd0;
      s1_m       <= 7'd0;
      pos_bin    <= 7'(START_POS);
      zero_count <= '0;
      bcd_err    <= 1'b0;
      done       <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_dir  <= in_dir;
        s1_h    <= in_mod;
        s1_m    <= m_bin;
        s1_last <= in_last;
        if (digit_err) bcd_err <= 1'b1;
      end
      if (s1_valid) begin
        pos_bin    <= pos_new;
        zero_count <= zc_next;
        if (s1_last) done <= 1'b1;
      end
    end
  end

`ifdef DIAL_LAND_COUNT_EN
  logic [COUNT_W:0] lc_sum;

  assign lc_sum = {1'b0, land_count} + (COUNT_W+1)'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      land_count <= '0;
    end else if (restart) begin
      land_count <= '0;
    end else if (s1_valid && (pos_new == 7'd0)) begin
      land_count <= lc_sum[COUNT_W] ? '1 : lc_sum[COUNT_W-1:0];
    end
  end
`endif

endmodule

// File: tb/tb_dial_tracker.sv
// Scoreboard bench for dial_tracker: the driver queues hand-computed results, a monitor
// checks them when each accepted rotation retires.
module tb_dial_tracker;

  localparam int COUNT_W = 16;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic               in_dir = 1'b0;
  logic [3:0]         in_mod = 4'd0;
  logic [7:0]         in_val = 8'd0;
  logic               in_last = 1'b0;
  logic               restart = 1'b0;
  logic [6:0]         pos_bin;
  logic [COUNT_W-1:0] zero_count;
`ifdef DIAL_LAND_COUNT_EN
  logic [COUNT_W-1:0] land_count;
`endif
  logic               bcd_err;
  logic               done;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [6:0]         pos;
    logic [COUNT_W-1:0] zc;
    logic [COUNT_W-1:0] lc;
    logic               dn;
  } exp_t;

  exp_t       expq[$];
  logic [1:0] pipe;

  always #5 clk = ~clk;

  dial_tracker #(.COUNT_W(COUNT_W), .START_POS(50)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_dir     (in_dir),
    .in_mod     (in_mod),
    .in_val     (in_val),
    .in_last    (in_last),
    .restart    (restart),
    .pos_bin    (pos_bin),
    .zero_count (zero_count),
`ifdef DIAL_LAND_COUNT_EN
    .land_count (land_count),
`endif
    .bcd_err    (bcd_err),
    .done       (done)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Queue the expected result, then hold the rotation until it is accepted.
  task automatic applyStimulus(input logic dir, input logic [3:0] md, input logic [7:0] vl,
                               input logic lst, input int epos, input int ezc, input int elc,
                               input logic edn);
    exp_t e;
    int   waitc;
    e.pos = 7'(epos);
    e.zc  = COUNT_W'(ezc);
    e.lc  = COUNT_W'(elc);
    e.dn  = edn;
    expq.push_back(e);
    in_valid = 1'b1;
    in_dir   = dir;
    in_mod   = md;
    in_val   = vl;
    in_last  = lst;
    waitc    = 0;
    do begin
      @(negedge clk);
      waitc++;
    end while (!in_ready && waitc < 20);
    if (!in_ready) checkOutput("accept timeout", 32'(in_ready), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // A rotation seen accepted at negedge k retires on the second following posedge.
  always @(negedge clk) begin
    if (!rst_n) begin
      pipe = 2'b00;
      expq.delete();
    end else begin
      if (pipe[1]) begin
        if (expq.size() == 0) begin
          checkOutput("scoreboard underflow", 1, 0);
        end else begin
          exp_t e;
          e = expq.pop_front();
          checkOutput("sb pos_bin", 32'(pos_bin), 32'(e.pos));
          checkOutput("sb zero_count", 32'(zero_count), 32'(e.zc));
          checkOutput("sb done", 32'(done), 32'(e.dn));
`ifdef DIAL_LAND_COUNT_EN
          checkOutput("sb land_count", 32'(land_count), 32'(e.lc));
`endif
        end
      end
      pipe[1] = pipe[0];
      pipe[0] = in_valid & in_ready & ~restart;
    end
  end

  initial begin
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    checkOutput("reset pos_bin", 32'(pos_bin), 50);
    checkOutput("reset zero_count", 32'(zero_count), 0);
    checkOutput("reset bcd_err", 32'(bcd_err), 0);
    checkOutput("reset done", 32'(done), 0);
    checkOutput("reset in_ready", 32'(in_ready), 0);
    waitCycles(2);
    rst_n = 1'b1;
    waitCycles(1);
    checkOutput("run in_ready", 32'(in_ready), 1);

    // Single turns and full-turn counts.
    applyStimulus(1'b1, 4'd0,  8'h50, 1'b0,  0,  1, 1, 1'b0);
    applyStimulus(1'b0, 4'd0,  8'h05, 1'b0, 95,  1, 1, 1'b0);
    applyStimulus(1'b1, 4'd0,  8'h05, 1'b0,  0,  2, 2, 1'b0);
    applyStimulus(1'b1, 4'd1,  8'h00, 1'b0,  0,  3, 3, 1'b0);
    applyStimulus(1'b0, 4'd0,  8'h50, 1'b0, 50,  3, 3, 1'b0);
    applyStimulus(1'b0, 4'd10, 8'h00, 1'b0, 50, 13, 3, 1'b0);
    waitCycles(3);

    restart = 1'b1;
    waitCycles(1);
    restart = 1'b0;
    checkOutput("restart pos_bin", 32'(pos_bin), 50);
    checkOutput("restart zero_count", 32'(zero_count), 0);
    checkOutput("restart in_ready", 32'(in_ready), 0);
    waitCycles(1);

    // Sample puzzle input, streamed back to back.
    applyStimulus(1'b0, 4'd0, 8'h68, 1'b0, 82, 1, 0, 1'b0);
    applyStimulus(1'b0, 4'd0, 8'h30, 1'b0, 52, 1, 0, 1'b0);
    applyStimulus(1'b1, 4'd0, 8'h48, 1'b0,  0, 2, 1, 1'b0);
    applyStimulus(1'b0, 4'd0, 8'h05, 1'b0, 95, 2, 1, 1'b0);
    applyStimulus(1'b1, 4'd0, 8'h60, 1'b0, 55, 3, 1, 1'b0);
    applyStimulus(1'b0, 4'd0, 8'h55, 1'b0,  0, 4, 2, 1'b0);
    applyStimulus(1'b0, 4'd0, 8'h01, 1'b0, 99, 4, 2, 1'b0);
    applyStimulus(1'b0, 4'd0, 8'h99, 1'b0,  0, 5, 3, 1'b0);
    applyStimulus(1'b1, 4'd0, 8'h14, 1'b0, 14, 5, 3, 1'b0);
    applyStimulus(1'b0, 4'd0, 8'h82, 1'b1, 32, 6, 3, 1'b1);

    // A rotation offered in DONE must be ignored.
    in_valid = 1'b1;
    in_dir   = 1'b1;
    in_mod   = 4'd5;
    in_val   = 8'h11;
    waitCycles(4);
    checkOutput("done in_ready", 32'(in_ready), 0);
    checkOutput("done pos_bin hold", 32'(pos_bin), 32);
    checkOutput("done zero_count hold", 32'(zero_count), 6);
    checkOutput("done held", 32'(done), 1);
`ifdef DIAL_LAND_COUNT_EN
    checkOutput("done land_count hold", 32'(land_count), 3);
`endif
    in_valid = 1'b0;
    restart  = 1'b1;
    waitCycles(1);
    restart = 1'b0;
    checkOutput("restart done", 32'(done), 0);
    waitCycles(1);

    // Illegal tens digit clamps to 9 and sets the sticky flag.
    applyStimulus(1'b1, 4'd0, 8'hA3, 1'b0, 43, 1, 0, 1'b0);
    waitCycles(3);
    checkOutput("bcd_err tens", 32'(bcd_err), 1);

    restart  = 1'b1;
    in_valid = 1'b1;
    in_dir   = 1'b1;
    in_mod   = 4'd0;
    in_val   = 8'h50;
    waitCycles(1);
    restart  = 1'b0;
    in_valid = 1'b0;
    checkOutput("restart drop pos_bin", 32'(pos_bin), 50);
    checkOutput("restart drop zero_count", 32'(zero_count), 0);
    checkOutput("restart bcd_err", 32'(bcd_err), 0);
    waitCycles(2);
    checkOutput("dropped rotation pos_bin", 32'(pos_bin), 50);

    applyStimulus(1'b1, 4'd0, 8'h1F, 1'b0, 69, 0, 0, 1'b0);
    waitCycles(3);
    checkOutput("bcd_err ones", 32'(bcd_err), 1);

    // Reset with a rotation in stage 1.
    applyStimulus(1'b1, 4'd2, 8'h31, 1'b0, 0, 0, 0, 1'b0);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset pos_bin", 32'(pos_bin), 50);
    checkOutput("midreset zero_count", 32'(zero_count), 0);
    checkOutput("midreset bcd_err", 32'(bcd_err), 0);
    checkOutput("midreset in_ready", 32'(in_ready), 0);
    waitCycles(2);
    rst_n = 1'b1;
    waitCycles(1);
    checkOutput("post-reset pos_bin", 32'(pos_bin), 50);

    applyStimulus(1'b1, 4'd0, 8'h50, 1'b1, 0, 1, 1, 1'b1);
    waitCycles(3);
    checkOutput("queue drained", 32'(expq.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/dial_tracker.md
Name: dial_tracker

Overview:
- Downstream of the 10-bit-to-BCD converter in the Puzzle 1 part-2 datapath; one rotation is consumed per handshake.
- Input per rotation: direction, hundreds digit (full turns) and two-digit BCD remainder of the rotation distance.
- Tracks the 0..99 dial position, starting at 50, and counts every click that lands the dial on 0 (the part-2 answer).
- Raises done after the last rotation, with the final count held stable.

Parameters:
- COUNT_W, 16, width of the zero-click counter (saturating).
- START_POS, 50, dial position after reset and after restart.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  rotation present on in_* this cycle
- in_ready  output  1  block can accept a rotation this cycle
- in_dir  input  1  0 = L (decrement), 1 = R (increment)
- in_mod  input  4  hundreds digit of distance = full turns (0..10)
- in_val  input  8  BCD remainder: [7:4] tens, [3:0] ones
- in_last  input  1  marks final rotation of the puzzle input
- restart  input  1  synchronous clear back to IDLE, position START_POS, counts 0
- pos_bin  output  7  current dial position, binary 0..99
- zero_count  output  COUNT_W  part-2 click-on-zero total
- bcd_err  output  1  sticky; a tens or ones digit > 9 was accepted
- done  output  1  final result valid

Behaviour:
- Reset is asynchronous, active low, on rst_n. Reset values:
  - state IDLE, pos_bin = START_POS, zero_count = 0
  - bcd_err = 0, done = 0, in_ready = 0
- States: IDLE -> RUN (one cycle after reset release, or after restart) -> DONE (after accepting in_last) -> IDLE only via restart or reset.
- in_ready = 1 only in RUN. Accept = in_valid & in_ready. Throughput is one rotation per cycle.
- in_* are sampled only on accept and ignored otherwise. The upstream source holds in_* while in_valid & !in_ready.
- Stage 1 (accept edge) registers:
  - dir, h = in_mod
  - m = tens*10 + ones (7-bit; bcd2bin_2d)
  - last flag, and a valid bit
- Stage 2 (next edge) uses registered p = pos_bin:
  - R: inc = h + (p + m >= 100); new p = (p + m) mod 100.
  - L: inc = h + (p != 0 && m >= p && m != 0); new p = (p - m) mod 100, computed as p - m + 100 when m > p.
  - m = 0: inc = h and position is unchanged, in both directions.
- Latency: pos_bin and zero_count reflect a rotation 2 cycles after its accept edge. Back-to-back rotations chain correctly because stage 2 always uses the freshly updated p.
- zero_count saturates at all-ones and never wraps.
- Illegal BCD digit (> 9): set bcd_err. Clamp that digit to 9 and continue processing.
- in_mod > 10 is legal and is added unchanged.
- done rises on the edge stage 2 retires the last-flagged rotation. done, pos_bin and zero_count then hold until restart.
- restart has priority over accept in the same cycle. It also flushes stage 1.
- Reset mid-operation discards any in-flight rotation.

Optional Feature:
- Macro: DIAL_LAND_COUNT_EN.
- Defined:
  - Adds output land_count [COUNT_W-1:0], the part-1 answer: increments by 1 when stage 2 leaves new p == 0.
  - Same reset, saturation, restart and latency rules as zero_count.
- Undefined: port and logic are absent. All other behaviour is identical.

Decomposition:
- Package dial_pkg:
  - DIAL_SIZE = 100
  - DIR_L = 1'b0, DIR_R = 1'b1
  - state enum {IDLE, RUN, DONE}
  - default START_POS
- Sub-module bcd2bin_2d: combinational, 8-bit BCD -> 7-bit binary with digit clamp and err flag. The top holds all sequential logic.

Test Plan:
- Reset, then R mod=0 val=0x50: pos 50 -> 0, zero_count = 1; pos_bin = 0 two cycles after accept.
- From 50, L mod=10 val=0x00 (distance 1000): pos 50, zero_count = 10.
- AoC sample streamed back to back: L68, L30, R48, L5, R60, L55, L1, L99, R14, L82 (in_last on L82) -> zero_count = 6, pos_bin = 32, done = 1; with DIAL_LAND_COUNT_EN, land_count = 3.
- From 0, L mod=0 val=0x05: pos 95, zero_count += 0. From 0, R mod=1 val=0x00: pos 0, +1.
- in_val = 0xA3: bcd_err = 1 sticky, digit treated as 9 (m = 93). Then restart asserted together with in_valid: rotation dropped, pos 50, counts 0, bcd_err 0.
- in_valid held through DONE: in_ready = 0, no count change; rst_n pulsed mid-stream: all outputs return to reset values immediately.
